// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RISC definitions: opcodes, default widths and the fetch-unit state encoding.
package instruction_fetch_unit_pkg;

    localparam int unsigned IW_DEF = 12;
    localparam int unsigned AW_DEF = 8;

    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_LD  = 3'b011;
    localparam logic [2:0] OP_ST  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: async active-low clear, jump load with priority over increment.
module program_counter #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          inc_i,
    input  logic [AW-1:0] tgt_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = tgt_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request, registered instruction with valid/ready.
// Optional IFU_PERF_CNT_EN adds saturating fetch/stall counters.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] ins,
    output logic [AW-1:0] ins_pc,
    output logic          ins_valid,
    input  logic          ins_ready,
    input  logic          jc,
    input  logic [AW-1:0] jmp_tgt
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]   fetch_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    ifu_state_e    state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] ins_q, ins_d;
    logic [AW-1:0] ins_pc_q, ins_pc_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] pc;
    logic          pc_load, pc_inc;
    logic          hs;

    assign hs = valid_q & ins_ready;

    program_counter #(.AW(AW)) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pc_load),
        .inc_i  (pc_inc),
        .tgt_i  (jmp_tgt),
        .pc_o   (pc)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        ins_d    = ins_q;
        ins_pc_d = ins_pc_q;
        valid_d  = valid_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    ins_d    = imem_rdata;
                    ins_pc_d = pc;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    pc_inc   = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                    // Request address is registered here, so the jump target bypasses the PC.
                    if (jc) begin
                        pc_load = 1'b1;
                        addr_d  = jmp_tgt;
                    end else begin
                        addr_d  = pc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            addr_q   <= '0;
            ins_q    <= '0;
            ins_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            ins_q    <= ins_d;
            ins_pc_q <= ins_pc_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = valid_q;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = ((state_q == HOLD) && !ins_ready) || ((state_q == FETCH) && !imem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (hs && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit (memory and decoder models).
module tb_instruction_fetch_unit;

    localparam int IW = 12;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [IW-1:0] imem_rdata;
    logic [IW-1:0] ins;
    logic [AW-1:0] ins_pc;
    logic          ins_valid;
    logic          ins_ready;
    logic          jc;
    logic [AW-1:0] jmp_tgt;
`ifdef IFU_PERF_CNT_EN
    logic [15:0]   fetch_cnt;
    logic [15:0]   stall_cnt;
`endif

    instruction_fetch_unit #(.IW(IW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .ins_pc     (ins_pc),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .jc         (jc),
        .jmp_tgt    (jmp_tgt)
`ifdef IFU_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] w;
        logic [AW-1:0] a;
    } exp_t;

    logic [IW-1:0] mem [256];
    exp_t          exp_q [$];
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [AW-1:0] model_addr = '0;
    int            phase = 0;
    int            hs_cnt = 0;
    int            cyc = 0;
    int            last_hs = 0;
    int unsigned   stall_exp = 0;
    int unsigned   fetch_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Instruction memory: one response per request, wait 0 (phase 0), 3 (phase 1), random later.
    logic pending = 1'b0;
    int   wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        imem_ack   = 1'b0;
        imem_rdata = IW'($urandom);
        if (!rst_n) begin
            pending = 1'b0;
        end else if (imem_req) begin
            if (!pending) begin
                pending  = 1'b1;
                wait_cnt = (phase == 0) ? 0 : (phase == 1) ? 3 : int'($urandom_range(0, 3));
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                exp_q.push_back('{w: mem[model_addr], a: model_addr});
                pending    = 1'b0;
            end else begin
                wait_cnt--;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            imem_ack = 1'b1;
        end
    end

    // Decoder model: ready/jump stimulus, with targets biased to the interesting cases.
    always @(posedge clk) begin
        #1;
        if (phase < 2) begin
            ins_ready = 1'b1;
            jc        = 1'b0;
            jmp_tgt   = AW'($urandom);
        end else begin
            ins_ready = ($urandom_range(0, 2) != 0);
            jc        = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       jmp_tgt = 8'h40;
                1:       jmp_tgt = 8'hFF;
                2:       jmp_tgt = ins_pc + 8'd1;
                3:       jmp_tgt = ins_pc;
                default: jmp_tgt = AW'($urandom);
            endcase
        end
    end

    // Monitor: compares DUT outputs against the reference fetch-order model.
    logic prev_ack = 1'b0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ack   = 1'b0;
            prev_stall = 1'b0;
            stall_exp  = 0;
            fetch_exp  = 0;
        end else begin
            cyc++;
            if (imem_req) check("imem_addr", 32'(imem_addr), 32'(model_addr));
            if (ins_valid) check("req_low_in_hold", 32'(imem_req), 32'd0);
            if (prev_ack) check("ack_to_valid", 32'(ins_valid), 32'd1);
            if (prev_stall) check("valid_held", 32'(ins_valid), 32'd1);
            if (imem_req && imem_ack) check("valid_during_ack", 32'(ins_valid), 32'd0);
            if ((ins_valid && !ins_ready) || (imem_req && !imem_ack)) stall_exp++;
            if (ins_valid && ins_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ins", 32'(ins_valid), 32'd0);
                    e = '{w: '0, a: ins_pc};
                end else begin
                    e = exp_q.pop_front();
                    check("ins", 32'(ins), 32'(e.w));
                    check("ins_pc", 32'(ins_pc), 32'(e.a));
                end
                hs_cnt++;
                fetch_exp++;
                if (phase == 0 && hs_cnt > 1) check("throughput", 32'(cyc - last_hs), 32'd2);
                last_hs    = cyc;
                model_addr = jc ? jmp_tgt : e.a + 8'd1;
                phase      = (hs_cnt < 3) ? 0 : (hs_cnt < 6) ? 1 : 2;
            end
            prev_ack   = imem_req && imem_ack;
            prev_stall = ins_valid && !ins_ready;
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_imem_req"},  32'(imem_req),  32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_ins"},       32'(ins),       32'd0);
        check({tag, "_ins_pc"},    32'(ins_pc),    32'd0);
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
`ifdef IFU_PERF_CNT_EN
        check({tag, "_fetch_cnt"}, 32'(fetch_cnt), 32'd0);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    task automatic run_until(input int target, input string tag);
        int n;
        n = 0;
        while (hs_cnt < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (hs_cnt < target) check({tag, "_timeout"}, 32'(hs_cnt), 32'(target));
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ins_ready  = 1'b0;
        jc         = 1'b0;
        jmp_tgt    = '0;
        for (int i = 0; i < 256; i++) mem[i] = IW'($urandom);
        mem[0] = 12'hA01;
        mem[1] = 12'hB02;
        mem[2] = 12'hC03;
        repeat (3) @(posedge clk);
        #2;
        check_reset_state("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_until(300, "run");

        n = 0;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_before_reset", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_addr = '0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        run_until(hs_cnt + 40, "post_rst");

`ifdef IFU_PERF_CNT_EN
        @(negedge clk);
        #1;
        check("fetch_cnt", 32'(fetch_cnt), 32'(fetch_exp));
        check("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
